mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sits between the execute-stage ALU and the word-only data memory of the three-stage RV32IS core.
- Aligns loads from the 32-bit memory word and sign- or zero-extends them.
- Turns byte and halfword stores into a two-cycle read-modify-write, because the data memory writes whole words only.
- Detects misaligned and out-of-range accesses and stalls the upstream pipeline while a read-modify-write is in flight.

Parameters:
- MEM_BASE, 32'h0000_0000, lowest legal byte address (inclusive).
- MEM_END, 32'h0000_FFFF, highest legal byte address (inclusive).

Ports:
- clk  in  1  core clock; the data memory writes on negedge clk.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory instruction present this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU).
- req_addr  in  32  byte address (ALU output).
- req_wdata  in  32  store data (rs2).
- stall  out  1  upstream must hold its request and registers.
- rsp_valid  out  1  registered load result valid.
- rsp_rdata  out  32  extended load data.
- fault  out  1  one-cycle pulse for a misaligned, out-of-range or illegal-size request.
- mem_addr  out  32  word-aligned address to data memory ({req_addr[31:2],2'b00}).
- mem_rw  out  1  1 = write (sampled at negedge clk), 0 = read.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read word from data memory.

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE, stall=0, rsp_valid=0, rsp_rdata=0, fault=0, mem_rw=0, mem_wdata=0, captured word=0. Deasserting rst_n mid-RMW aborts the RMW with no write.
- mem_rw must never be 1 except in the cases below; it is driven combinationally from state and request.
- Legality check, combinational:
  - misaligned = (size==01 && addr[0]) || (size==10 && addr[1:0]!=0).
  - illegal = size==11 || addr<MEM_BASE || addr>MEM_END.
  - On any of these: no memory write, fault=1 on the next cycle, rsp_valid=0, and the FSM stays IDLE.
- FSM states: IDLE, RMW_WR.
- Load in IDLE (legal):
  - mem_rw=0.
  - At posedge, rsp_rdata is registered as the byte/half selected by addr[1:0], little-endian, extended per req_unsigned.
  - rsp_valid=1 for exactly one cycle. Latency is 1 cycle; there is no stall.
- Word store in IDLE (legal): mem_rw=1 and mem_wdata=req_wdata in the same cycle; memory writes at negedge. No stall, no rsp_valid.
- Sub-word store in IDLE (legal):
  - Cycle 1: mem_rw=0, stall=1. At posedge, capture mem_rdata plus the lane, size and data; go to RMW_WR.
  - Cycle 2 (RMW_WR): mem_rw=1, mem_wdata = captured word with the target byte lanes replaced by req_wdata[7:0] or req_wdata[15:0]; stall=0; next state IDLE.
  - Total: 2 cycles, 1 stall cycle.
- In RMW_WR the request inputs are ignored because upstream is held. The captured address is used, not live req_addr.
- req_valid=0: mem_rw=0, rsp_valid=0 next cycle, and rsp_rdata holds its last value.
- Back-to-back: a load immediately after an RMW store to the same word sees the merged data, because the write completes at the negedge before the load's read cycle.

Decomposition:
- Shared riscv package/header gets these constants: MEM_SIZE_B=2'b00, MEM_SIZE_H=2'b01, MEM_SIZE_W=2'b10, the FSM state encodings, and the BITS32/BITS2 width macros.
- One sub-module, mem_lane_align: combinational byte-lane select and extend for loads plus the merge for stores. It is shared by both paths and unit-testable in isolation.

Test Plan:
- Memory word @0x100 = 0x8877_6655:
  - LB @0x103 → rsp_rdata=0xFFFF_FF88, rsp_valid one cycle later.
  - LBU @0x103 → 0x0000_0088.
  - LH @0x102 → 0xFFFF_8877.
- SW 0xDEAD_BEEF @0x200 → mem_rw=1 for one cycle, no stall. A subsequent LW @0x200 returns 0xDEAD_BEEF.
- Word @0x300=0x1122_3344:
  - SB 0xAB @0x301 → stall for 1 cycle, then mem_wdata=0x1122_AB44; LW returns that value.
  - SH 0xCAFE @0x302 → 0xCAFE_AB44.
- LH @0x101, SW @0x202, and size=11 → fault pulse, mem_rw never 1, rsp_valid=0, word @0x200 unchanged.
- Access @MEM_END+1 → fault. Access @MEM_END-3 (LW) → succeeds.
- Assert rst_n=0 during RMW_WR of SB @0x301 → no write occurs; all outputs go to reset values immediately (asynchronously); FSM is IDLE after rst_n is released.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, FSM encoding and RMW context for the RV32IS data-memory access unit.
package mem_access_unit_pkg;

  localparam int BITS32 = 32;
  localparam int BITS2  = 2;

  localparam logic [BITS2-1:0] MEM_SIZE_B = 2'b00;
  localparam logic [BITS2-1:0] MEM_SIZE_H = 2'b01;
  localparam logic [BITS2-1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } mau_state_e;

  // Everything the write half of a read-modify-write needs once upstream is frozen.
  typedef struct packed {
    logic [BITS32-1:0] addr;
    logic [BITS2-1:0]  lane;
    logic [BITS2-1:0]  size;
    logic [BITS32-1:0] data;
    logic [BITS32-1:0] word;
  } rmw_ctx_t;

  function automatic logic is_misaligned(input logic [BITS2-1:0] size,
                                         input logic [BITS2-1:0] lane);
    return ((size == MEM_SIZE_H) && lane[0]) ||
           ((size == MEM_SIZE_W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane select/extend for loads and lane merge for sub-word stores, little-endian.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [BITS32-1:0] word,
  input  logic [BITS2-1:0]  lane,
  input  logic [BITS2-1:0]  size,
  input  logic              is_unsigned,
  input  logic [BITS32-1:0] wdata,
  output logic [BITS32-1:0] load_data,
  output logic [BITS32-1:0] merged
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b     = word[{lane, 3'b000} +: 8];
    sel_h     = word[{lane[1], 4'b0000} +: 16];
    load_data = word;
    merged    = word;
    case (size)
      MEM_SIZE_B: begin
        load_data = {{24{~is_unsigned & sel_b[7]}}, sel_b};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      MEM_SIZE_H: begin
        load_data = {{16{~is_unsigned & sel_h[15]}}, sel_h};
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load alignment, word stores, and two-cycle byte/half read-modify-write against a word-only data memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [BITS32-1:0] MEM_BASE = 32'h0000_0000,
  parameter logic [BITS32-1:0] MEM_END  = 32'h0000_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [BITS2-1:0]  req_size,
  input  logic              req_unsigned,
  input  logic [BITS32-1:0] req_addr,
  input  logic [BITS32-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [BITS32-1:0] rsp_rdata,
  output logic              fault,
  output logic [BITS32-1:0] mem_addr,
  output logic              mem_rw,
  output logic [BITS32-1:0] mem_wdata,
  input  logic [BITS32-1:0] mem_rdata
);

  mau_state_e state;
  rmw_ctx_t   ctx;

  logic              is_idle, misaligned, illegal, bad, ok;
  logic              ld_go, wd_st, sub_st;
  logic [BITS32-1:0] align_word, load_data, merged;
  logic [BITS2-1:0]  align_lane, align_size;

  assign is_idle    = (state == IDLE);
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  // Offset compare covers both bounds: addresses below MEM_BASE wrap to large values.
  assign illegal    = (req_size == 2'b11) ||
                      ((req_addr - MEM_BASE) > (MEM_END - MEM_BASE));
  assign bad        = misaligned || illegal;
  assign ok         = req_valid && is_idle && !bad;
  assign ld_go      = ok && !req_we;
  assign wd_st      = ok && req_we && (req_size == MEM_SIZE_W);
  assign sub_st     = ok && req_we && (req_size != MEM_SIZE_W);

  // One aligner serves both paths: live request in IDLE, captured context in RMW_WR.
  assign align_word = is_idle ? mem_rdata      : ctx.word;
  assign align_lane = is_idle ? req_addr[1:0]  : ctx.lane;
  assign align_size = is_idle ? req_size       : ctx.size;

  mem_lane_align u_align (
    .word        (align_word),
    .lane        (align_lane),
    .size        (align_size),
    .is_unsigned (req_unsigned),
    .wdata       (ctx.data),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign stall     = rst_n && sub_st;
  assign mem_rw    = rst_n && (wd_st || !is_idle);
  assign mem_addr  = is_idle ? {req_addr[31:2], 2'b00} : ctx.addr;
  assign mem_wdata = !rst_n  ? '0 :
                     !is_idle ? merged :
                     wd_st    ? req_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      fault     <= 1'b0;
      ctx       <= '0;
    end else begin
      rsp_valid <= ld_go;
      fault     <= req_valid && is_idle && bad;
      if (ld_go) rsp_rdata <= load_data;
      if (is_idle) begin
        if (sub_st) begin
          state    <= RMW_WR;
          ctx.addr <= {req_addr[31:2], 2'b00};
          ctx.lane <= req_addr[1:0];
          ctx.size <= req_size;
          ctx.data <= req_wdata;
          ctx.word <= mem_rdata;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
